hilo_unit: RTL
==============

// Module: hilo_unit
// PURPOSE
//  Multi-cycle multiply/divide unit owning the HI/LO architectural registers. Consumes rs/rt operands
//  for mult/multu/div/divu/mthi/mtlo and presents HI/LO for mfhi/mflo. Sits beside the ALU in execute.
//  Raises busy so the pipeline control stalls any mf*/mt*/mult/div issue while an operation is in flight.
// PARAMETERS
//  WIDTH  32  operand and HI/LO width; only 32 is verified
// PORTS
//  clk    in   1      rising-edge clock
//  rst_n  in   1      asynchronous, active-low reset
//  start  in   1      issue op this cycle; accepted only when busy=0
//  op     in   3      md_op_t: MULT=0 MULTU=1 DIV=2 DIVU=3 MTHI=4 MTLO=5 (6,7 ignored)
//  a      in   WIDTH  rs value (multiplicand, dividend, or mthi/mtlo source)
//  b      in   WIDTH  rt value (multiplier or divisor)
//  busy   out  1      iterative op in progress
//  done   out  1      one-cycle pulse when new mult/div result is first visible on hi/lo
//  hi     out  WIDTH  HI register: product[63:32] or remainder
//  lo     out  WIDTH  LO register: product[31:0] or quotient
// BEHAVIOUR
//  Reset (async, any time including mid-op): hi=lo=0, busy=0, done=0, state IDLE, counter=0, op discarded.
//  FSM IDLE -> RUN -> FIX -> IDLE.
//   IDLE: start & op in {MULT..DIVU}: latch |a|,|b| (signed ops) or a,b, sign flags, opcode; cnt=0; go RUN.
//         start & MTHI: hi<=a next edge; MTLO: lo<=a next edge; stay IDLE; busy stays 0; done stays 0.
//         start with op 6/7: no effect.
//   RUN : one radix-2 step per cycle; cnt 0..31; after step 31 go FIX. Multiply: shift-add into 64-bit acc.
//         Divide: restoring shift-subtract; rem in upper half, quotient shifted into lower half.
//   FIX : apply sign correction; write hi/lo on the FIX->IDLE edge; done=1 for the following cycle.
//  Timing: start sampled at edge E -> busy=1 from E to E+33 (33 cycles) -> hi/lo and done=1 updated at E+33.
//  hi/lo keep previous values throughout RUN/FIX (mfhi/mflo stall on busy; no forwarding of partials).
//  start while busy=1 is ignored entirely, including MTHI/MTLO; control must hold the request.
//  Arithmetic:
//   MULT : {hi,lo} = signed(a)*signed(b), full 64-bit two's complement. MULTU: unsigned 64-bit.
//   DIVU : lo = a/b, hi = a%b. DIV: quotient truncates toward zero; remainder takes sign of dividend.
//   b==0 : lo = 32'hFFFF_FFFF, hi = a (both DIV and DIVU); still 33 cycles, done pulses.
//   DIV 32'h8000_0000 / 32'hFFFF_FFFF : lo = 32'h8000_0000, hi = 0 (wraps, no trap).
//  Sign handling: negate operands to magnitude on entry; negate product if sa^sb; negate quotient if sa^sb;
//   negate remainder if sa. All negations are 2's complement in WIDTH or 2*WIDTH bits.
//  done and busy are never high together; done=1 coincides with busy=0 and state IDLE.
// STRUCTURE
//  Shared package mips_pkg: md_op_t enum (6 encodings above), MD_ITER=32 constant, state enum
//   {IDLE,RUN,FIX}.
//  One sub-module: muldiv_iter (64-bit acc, 32-bit operand reg, cnt, single step/cycle for mul or div,
//   outputs raw magnitude result). hilo_unit keeps FSM, sign fix, HI/LO regs, mt* writes.
// TESTING
//  MULT a=32'hFFFF_FFFD (-3), b=5 -> after 33 cycles hi=FFFF_FFFF, lo=FFFF_FFF1, done 1 cycle.
//  MULTU a=b=32'hFFFF_FFFF -> hi=FFFF_FFFE, lo=0000_0001; busy high exactly 33 cycles.
//  DIV a=-7 (FFFF_FFF9), b=2 -> lo=FFFF_FFFD, hi=FFFF_FFFF; DIV 8000_0000/FFFF_FFFF -> lo=8000_0000, hi=0.
//  DIVU a=7, b=0 -> lo=FFFF_FFFF, hi=7; then DIVU 100/7 -> lo=14, hi=2.
//  MTHI a=1234_5678 idle -> hi=1234_5678 next edge, busy stays 0; MTLO issued while busy -> lo unchanged.
//  Start MULT, drop rst_n at cycle 10 mid-RUN -> hi=lo=0, busy=0 immediately; restart completes normally.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the HI/LO multiply/divide unit: opcodes,
// iteration count and FSM state encoding.
package mips_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_t;

  localparam int MD_ITER = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/hilo_unit_iter.sv
// Radix-2 iterative engine: one shift-add (multiply) or restoring
// shift-subtract (divide) step per cycle on unsigned magnitudes.
// The 2*WIDTH accumulator ends as the raw product, or as
// {remainder, quotient} for divides.
module muldiv_iter
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic               step_i,
  input  logic               div_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic [2*WIDTH-1:0] res_o,
  output logic               last_o
);

  localparam int CNT_W = $clog2(MD_ITER);

  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opd_q;
  logic               div_q;
  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     diff;

  // Step counter: cleared on load, advances once per iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= '0;
    end else if (step_i) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Datapath registers: operand latch on load, accumulator update per step
  always_ff @(posedge clk) begin
    if (load_i) begin
      acc_q <= {{WIDTH{1'b0}}, a_i};
      opd_q <= b_i;
      div_q <= div_i;
    end else if (step_i) begin
      acc_q <= acc_d;
    end
  end

  // Next accumulator: multiply adds into the upper half then shifts right;
  // divide shifts left and subtracts the divisor when it fits
  always_comb begin
    sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opd_q} : '0);
    rem_sh = acc_q[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, opd_q};
    acc_d  = acc_q;
    if (!div_q) begin
      acc_d = {sum, acc_q[WIDTH-1:1]};
    end else if (!diff[WIDTH]) begin
      acc_d = {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_d = {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end
  end

  assign res_o  = acc_q;
  assign last_o = (cnt_q == CNT_W'(MD_ITER - 1));

endmodule

// File: rtl/hilo_unit.sv
// HI/LO register owner with a multi-cycle multiply/divide behind it.
// Signed ops run on magnitudes; signs are restored in FIX before HI/LO
// are written. mthi/mtlo write directly when idle.
module hilo_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  md_state_t          state_q;
  md_op_t             op_q;
  logic               busy_q, done_q;
  logic               sa_q, sb_q, bz_q;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic [WIDTH-1:0]   hi_fix, lo_fix;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] res, prod;
  logic [WIDTH-1:0]   quo, rem;
  logic               is_md, is_sgn, load, last, op_div;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

  // Issue decode and operand magnitudes for the iterative engine
  always_comb begin
    is_md  = (op < 3'd4);
    is_sgn = (op == MD_MULT) || (op == MD_DIV);
    op_div = (op == MD_DIV) || (op == MD_DIVU);
    load   = (state_q == IDLE) && start && is_md;
    a_mag  = (is_sgn && a[WIDTH-1]) ? neg_w(a) : a;
    b_mag  = (is_sgn && b[WIDTH-1]) ? neg_w(b) : b;
  end

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (load),
    .step_i (state_q == RUN),
    .div_i  (op_div),
    .a_i    (a_mag),
    .b_i    (b_mag),
    .res_o  (res),
    .last_o (last)
  );

  // Sign restoration; a zero divisor forces an all-ones quotient
  always_comb begin
    prod   = (sa_q ^ sb_q) ? neg_2w(res) : res;
    quo    = res[WIDTH-1:0];
    rem    = res[2*WIDTH-1:WIDTH];
    hi_fix = prod[2*WIDTH-1:WIDTH];
    lo_fix = prod[WIDTH-1:0];
    if ((op_q == MD_DIV) || (op_q == MD_DIVU)) begin
      lo_fix = bz_q ? '1 : ((sa_q ^ sb_q) ? neg_w(quo) : quo);
      hi_fix = sa_q ? neg_w(rem) : rem;
    end
  end

  // Control FSM with registered busy/done and the HI/LO registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= MD_MULT;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      bz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            if (is_md) begin
              state_q <= RUN;
              busy_q  <= 1'b1;
              op_q    <= md_op_t'(op);
              sa_q    <= is_sgn & a[WIDTH-1];
              sb_q    <= is_sgn & b[WIDTH-1];
              bz_q    <= (b == '0);
            end else if (op == MD_MTHI) begin
              hi_q <= a;
            end else if (op == MD_MTLO) begin
              lo_q <= a;
            end
          end
        end
        RUN: begin
          if (last) state_q <= FIX;
        end
        FIX: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          hi_q    <= hi_fix;
          lo_q    <= lo_fix;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
